// File: rtl/tableau_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tableau_pkg : Pauli literal encoding, command opcodes and FSM states.  |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
package tableau_pkg;

   typedef logic [1:0] pauli_t;

   localparam pauli_t PAULI_I = 2'd0;
   localparam pauli_t PAULI_X = 2'd1;
   localparam pauli_t PAULI_Z = 2'd2;
   localparam pauli_t PAULI_Y = 2'd3;

   typedef enum logic [1:0] {
      OP_LOAD   = 2'd0,
      OP_ROTATE = 2'd1,
      OP_SWEEP  = 2'd2,
      OP_READ   = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ROTATE = 2'd1,
      ST_SWEEP  = 2'd2,
      ST_READ   = 2'd3
   } state_e;

endpackage
`default_nettype wire

// File: rtl/tableau_row.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tableau_row : one tableau row, literal shift/rotate register + phase.  |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module tableau_row
   import tableau_pkg::*;
#(
   parameter int NUM_QUBIT = 4
)
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   shift_en,
   input  logic [2*NUM_QUBIT-1:0] shift_lits,
   input  logic                   shift_phase,
   input  logic                   rot_en,
   input  logic [1:0]             rot_in,
   input  logic                   tgl,
   output logic [2*NUM_QUBIT-1:0] lits,
   output logic                   phase
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lits  <= {NUM_QUBIT{PAULI_I}};
         phase <= 1'b0;
      end else begin
         if (shift_en)
            lits <= shift_lits;
         else if (rot_en)
            lits <= {rot_in, lits[2*NUM_QUBIT-1:2]};

         // The toggle lands on whatever the row holds after a vertical shift.
         if (shift_en)
            phase <= shift_phase ^ tgl;
         else
            phase <= phase ^ tgl;
      end
   end

endmodule
`default_nettype wire

// File: rtl/tableau_register_array.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tableau_register_array : CHP stabilizer-tableau store with load, read, |
// | rotate and rotate-with-update sweeps. Option: TABLEAU_CIRCULAR_READ_EN |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module tableau_register_array
   import tableau_pkg::*;
#(
   parameter int NUM_QUBIT = 4,
   parameter int NUM_ROW   = 4,
   parameter int CNT_W     = $clog2(NUM_QUBIT + 1)
)
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [1:0]             cmd_op,
   input  logic [CNT_W-1:0]       cmd_arg,
   input  logic [2*NUM_QUBIT-1:0] row_in,
   input  logic                   phase_in,
   output logic [2*NUM_ROW-1:0]   col_out,
   output logic                   col_valid,
   input  logic [2*NUM_ROW-1:0]   upd_col,
   input  logic                   upd_valid,
   input  logic [NUM_ROW-1:0]     tgl_mask,
   input  logic                   tgl_valid,
   output logic                   tgl_ready,
   output logic [2*NUM_QUBIT-1:0] row_out,
   output logic                   phase_out,
   output logic                   row_out_valid,
   output logic                   done
);

   state_e                 state, state_nxt;
   logic [CNT_W-1:0]       cnt, cnt_nxt;
   logic                   done_q, done_nxt;
   logic                   load_shift, read_shift, rot_en, use_upd;
   logic                   tgl_fire;
   logic [2*NUM_QUBIT-1:0] lits [NUM_ROW];
   logic [NUM_ROW-1:0]     phase;
   logic [2*NUM_QUBIT-1:0] fill_lits;
   logic                   fill_phase;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         done_q <= done_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      done_nxt   = 1'b0;
      load_shift = 1'b0;
      read_shift = 1'b0;
      rot_en     = 1'b0;
      use_upd    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cmd_valid) begin
               case (cmd_op)
                  OP_LOAD: begin
                     load_shift = 1'b1;
                     done_nxt   = 1'b1;
                  end
                  OP_ROTATE: begin
                     if (cmd_arg == '0) begin
                        done_nxt = 1'b1;
                     end else begin
                        cnt_nxt   = cmd_arg;
                        state_nxt = ST_ROTATE;
                     end
                  end
                  OP_SWEEP: begin
                     cnt_nxt   = CNT_W'(NUM_QUBIT);
                     state_nxt = ST_SWEEP;
                  end
                  OP_READ: state_nxt = ST_READ;
                  default: ;
               endcase
            end
         end
         ST_ROTATE: begin
            rot_en  = 1'b1;
            cnt_nxt = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               done_nxt  = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         ST_SWEEP: begin
            if (upd_valid) begin
               rot_en  = 1'b1;
               use_upd = 1'b1;
               cnt_nxt = cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  done_nxt  = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end
         end
         ST_READ: begin
            read_shift = 1'b1;
            state_nxt  = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign cmd_ready     = (state == ST_IDLE);
   assign col_valid     = (state == ST_SWEEP);
   assign row_out_valid = (state == ST_READ);
   assign tgl_ready     = (state == ST_IDLE) || (state == ST_SWEEP);
   assign tgl_fire      = tgl_valid && tgl_ready;
   // The read beat is its own completion, so done is not delayed for it.
   assign done          = done_q || row_out_valid;
   assign row_out       = lits[NUM_ROW-1];
   assign phase_out     = phase[NUM_ROW-1];

`ifdef TABLEAU_CIRCULAR_READ_EN
   assign fill_lits  = lits[NUM_ROW-1];
   assign fill_phase = phase[NUM_ROW-1];
`else
   assign fill_lits  = {NUM_QUBIT{PAULI_I}};
   assign fill_phase = 1'b0;
`endif

   generate
      for (genvar i = 0; i < NUM_ROW; i++) begin : g_row
         logic [2*NUM_QUBIT-1:0] shift_lits;
         logic                   shift_phase;
         logic [1:0]             rot_in;

         if (i == 0) begin : g_head
            assign shift_lits  = load_shift ? row_in : fill_lits;
            assign shift_phase = load_shift ? phase_in : fill_phase;
         end else begin : g_body
            assign shift_lits  = lits[i-1];
            assign shift_phase = phase[i-1];
         end

         assign rot_in = use_upd ? upd_col[2*i +: 2] : lits[i][1:0];

         tableau_row #(
            .NUM_QUBIT (NUM_QUBIT)
         ) u_row (
            .clk         (clk),
            .rst         (rst),
            .shift_en    (load_shift || read_shift),
            .shift_lits  (shift_lits),
            .shift_phase (shift_phase),
            .rot_en      (rot_en),
            .rot_in      (rot_in),
            .tgl         (tgl_fire && tgl_mask[i]),
            .lits        (lits[i]),
            .phase       (phase[i])
         );

         assign col_out[2*i +: 2] = lits[i][1:0];
      end
   endgenerate

endmodule
`default_nettype wire

// File: doc/tableau_register_array.md
Name: tableau_register_array

Overview:
- Parametrised stabilizer-tableau store for the CHP conjugation datapath. Holds NUM_ROW rows of NUM_QUBIT 2-bit Pauli literals plus one phase bit per row.
- Sequences row load, row readout and column sweeps (pure rotate, or rotate-with-update) under its own FSM.
- Uses valid/ready handshakes, so the gate-update unit can stall each column step.

Parameters:
- NUM_QUBIT, 4, literal columns per row (>=2).
- NUM_ROW, 4, tableau rows (>=1); independent of NUM_QUBIT.
- CNT_W, $clog2(NUM_QUBIT+1), width of the column-count argument.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FSM in IDLE
- cmd_op  in  2  0 LOAD_ROW, 1 ROTATE, 2 SWEEP_UPDATE, 3 READ_ROW
- cmd_arg  in  CNT_W  ROTATE column count
- row_in  in  2*NUM_QUBIT  literals for LOAD_ROW; column 0 in the LSBs
- phase_in  in  1  phase for LOAD_ROW
- col_out  out  2*NUM_ROW  current column 0, all rows; row 0 in the LSBs
- col_valid  out  1  SWEEP_UPDATE step awaiting update
- upd_col  in  2*NUM_ROW  updated column, written into column NUM_QUBIT-1
- upd_valid  in  1  update accepted when col_valid && upd_valid
- tgl_mask  in  NUM_ROW  per-row phase toggle mask
- tgl_valid  in  1  toggle request
- tgl_ready  out  1  high in IDLE and SWEEP_UPDATE
- row_out  out  2*NUM_QUBIT  bottom row (NUM_ROW-1) literals
- phase_out  out  1  bottom row phase
- row_out_valid  out  1  one-cycle pulse, READ_ROW data beat
- done  out  1  one-cycle pulse on command completion

Behaviour:
- Reset: all literals 2'b00 (I), all phases 0, FSM IDLE, all counters 0. Outputs: cmd_ready=1, col_valid=0, row_out_valid=0, done=0, tgl_ready=1. rst mid-command aborts it with no done.
- FSM states: IDLE, ROTATE, SWEEP, READ. A command is accepted on cmd_valid && cmd_ready.
- LOAD_ROW, handled in IDLE:
  - Accept cycle: every row i>0 takes row i-1; row 0 takes row_in; phases shift the same way.
  - done pulses on the next cycle; the FSM stays in IDLE.
- ROTATE:
  - cnt loads cmd_arg. Each cycle, every row rotates left one column: col j takes col j+1; col NUM_QUBIT-1 takes col 0. cnt decrements.
  - When cnt reaches 0: done, return to IDLE.
  - cmd_arg=0: no shift; done on the cycle after accept.
  - cmd_arg=NUM_QUBIT: tableau unchanged after NUM_QUBIT cycles.
  - Values >NUM_QUBIT are legal and behave modulo NUM_QUBIT.
- SWEEP_UPDATE:
  - cnt loads NUM_QUBIT; col_valid=1 while in SWEEP.
  - Each handshake cycle: rotate left, with column NUM_QUBIT-1 taking upd_col instead of col 0; cnt decrements.
  - upd_valid low: hold (stall).
  - cnt reaching 0: done, col_valid=0, IDLE.
  - Phases are untouched by the sweep itself.
- READ_ROW:
  - Cycle after accept: row_out_valid=1 with the current bottom row on row_out/phase_out.
  - Same cycle: rows shift down; row 0 and phase 0 take I/0. done pulses with row_out_valid.
  - NUM_ROW consecutive reads empty the tableau.
- Phase toggle:
  - On tgl_valid && tgl_ready: phase[i] ^= tgl_mask[i].
  - Same cycle as a LOAD_ROW accept: the shift happens first and the mask applies to post-shift indices.
  - tgl_valid while tgl_ready=0: request ignored, no state change.
- row_out/phase_out always reflect the bottom row, combinationally.
- cmd_valid outside IDLE: ignored (cmd_ready=0).

Optional Feature:
- Macro TABLEAU_CIRCULAR_READ_EN.
- Defined: READ_ROW recirculates — row 0 takes the old bottom row and phase, so NUM_ROW reads return the tableau to its original state.
- Undefined: destructive read, row 0 fills with I and phase 0.

Decomposition:
- Package tableau_pkg holds:
  - typedef pauli_t (2-bit);
  - constants PAULI_I=0, PAULI_X=1, PAULI_Z=2, PAULI_Y=3;
  - enum op codes OP_LOAD, OP_ROTATE, OP_SWEEP, OP_READ;
  - enum FSM states.
- Sub-module tableau_row: one row's literal shift/rotate register plus phase bit, instantiated NUM_ROW times under the top-level FSM and counter.

Test Plan:
- Reset, then 4 LOAD_ROWs (rows X I I I, Z I I I, Y I I I, I X I I; phases 1,0,0,1) -> bottom row = X I I I, phase 1; done after each load.
- ROTATE cmd_arg=1 -> row 3 literals I I I X, done after 1 cycle. cmd_arg=4 -> tableau unchanged, done after 4 cycles. cmd_arg=0 -> done next cycle, no change.
- SWEEP_UPDATE, upd_col=all-Z each step, upd_valid low for 2 cycles at step 2 -> col_valid held through the stall. Result: every literal Z, done after 4 accepted steps.
- tgl_mask=4'b0101 concurrent with a LOAD_ROW of phase 0 -> post-shift phases toggled on rows 0 and 2 only.
- 4 READ_ROWs -> row_out sequence of rows 3,2,1,0; tableau all I (macro undefined) or restored to original (TABLEAU_CIRCULAR_READ_EN defined).
- rst asserted mid-SWEEP at step 2 -> all literals I, all phases 0, cmd_ready=1, no done pulse.
